// File: rtl/decode_pkg.sv
// Shared types for the instruction decode stage: field widths, opcode
// encodings, the packed instruction layout and the decode FSM states.
package decode_pkg;

    localparam int INSTR_W  = 9;
    localparam int OPCODE_W = 3;
    localparam int REG_W    = 2;
    localparam int IMM_W    = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_LD   = 3'b101,
        OP_ST   = 3'b110,
        OP_SWAP = 3'b111
    } opcode_e;

    // Field order matches the raw bit layout, so a cast splits the word.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    reg1;
        logic [REG_W-1:0]    reg2;
        logic [IMM_W-1:0]    imm;
    } instr_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    function automatic logic is_swap(input logic [OPCODE_W-1:0] op);
        return op == OP_SWAP;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready stage: an output register plus one skid register,
// with a registered upstream ready so no combinational path crosses the stage.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             allow,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             skid_valid_q;
    logic             skid_valid_d;
    logic             ready_q;
    logic             push;
    logic             out_free;

    assign push     = in_valid && ready_q;
    assign out_free = !out_valid_q || pop;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_d       = in_data;
                skid_valid_d = push;
            end else if (push) begin
                // Empty skid and a free output slot: bypass straight in.
                out_d       = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= allow && !skid_valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: rtl/instr_decode.sv
// Instruction decode stage: buffers fetched words, splits fields, pulses doSWAP
// and stops accepting on HALT_WORD. Define SWAP_HAZARD_EN for a post-SWAP bubble.
//
// state  | meaning
// RUN    | accepting instructions from fetch
// HALTED | HALT_WORD accepted; buffered words drain, only reset leaves
module instr_decode
    import decode_pkg::*;
#(
    parameter logic [INSTR_W-1:0] HALT_WORD = 9'h000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    reg1,
    output logic [REG_W-1:0]    reg2,
    output logic [IMM_W-1:0]    imm,
    output logic                doSWAP,
    output logic                halted
);

    state_e             state;
    state_e             state_next;
    logic               allow;
    logic               accept;
    logic               buf_valid;
    logic [INSTR_W-1:0] buf_data;
    logic               hold;
    logic               pop;
    instr_t             fields;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        allow      = 1'b0;
        case (state)
            RUN: begin
                if (accept && instr == HALT_WORD) begin
                    state_next = HALTED;
                end else begin
                    allow = 1'b1;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    skid_buffer #(
        .WIDTH(INSTR_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .allow    (allow),
        .in_valid (in_valid),
        .in_data  (instr),
        .in_ready (in_ready),
        .pop      (pop),
        .out_valid(buf_valid),
        .out_data (buf_data)
    );

`ifdef SWAP_HAZARD_EN
    // One dead cycle after each swap lets the mapping table settle.
    logic bubble_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_q <= 1'b0;
        end else begin
            bubble_q <= doSWAP;
        end
    end

    assign hold = bubble_q;
`else
    assign hold = 1'b0;
`endif

    assign fields    = instr_t'(buf_data);
    assign out_valid = buf_valid && !hold;
    assign pop       = out_valid && out_ready;
    assign opcode    = fields.opcode;
    assign reg1      = fields.reg1;
    assign reg2      = fields.reg2;
    assign imm       = fields.imm;
    assign doSWAP    = pop && is_swap(fields.opcode);
    assign halted    = (state == HALTED);

endmodule
